// File: rtl/registro_pkg.sv
// Shared definitions for the registro storage register: default width, word type, parity helper.
package registro_pkg;

  localparam int unsigned REGISTRO_DEFAULT_WIDTH = 8;

  typedef logic [REGISTRO_DEFAULT_WIDTH-1:0] registro_word_t;

  // Even parity: 1 when the word holds an odd number of ones.
  function automatic logic registro_parity(input registro_word_t word);
    return ^word;
  endfunction

endpackage

// File: rtl/registro_if.sv
// Data bus for registro: write data/enable in, stored value (and optional parity) out.
// Optional parity signal is present only when REGISTRO_PARITY_EN is defined.
interface registro_if #(
  parameter int unsigned WIDTH = 8
);

  logic [WIDTH-1:0] in;
  logic             we;
  logic [WIDTH-1:0] out;
`ifdef REGISTRO_PARITY_EN
  logic             parity;

  modport master (output in, output we, input out, input parity);
  modport slave  (input in, input we, output out, output parity);
`else
  modport master (output in, output we, input out);
  modport slave  (input in, input we, output out);
`endif

endinterface

// File: rtl/registro_bit.sv
// Single storage bit: synchronous active-low reset to rst_val, load d when we, else hold.
module registro_bit (
  input  logic clock,
  input  logic rst_n,
  input  logic rst_val,
  input  logic we,
  input  logic d,
  output logic q
);

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      q <= rst_val;
    end else if (we) begin
      q <= d;
    end
  end

endmodule

// File: rtl/registro.sv
// Edge-triggered WIDTH-bit register with write enable, built from registro_bit slices.
// Define REGISTRO_PARITY_EN to add a registered even-parity output tracking the stored word.
module registro
  import registro_pkg::*;
#(
  parameter int unsigned     WIDTH       = REGISTRO_DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic       clock,
  input  logic       rst_n,
  registro_if.slave  bus
);

  logic [WIDTH-1:0] q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    registro_bit u_bit (
      .clock   (clock),
      .rst_n   (rst_n),
      .rst_val (RESET_VALUE[i]),
      .we      (bus.we),
      .d       (bus.in[i]),
      .q       (q[i])
    );
  end

  assign bus.out = q;

`ifdef REGISTRO_PARITY_EN
  localparam logic ResetParity = ^RESET_VALUE;

  logic in_parity;
  logic parity_q;

  // Zero-extension into the package word type leaves parity unchanged.
  if (WIDTH <= REGISTRO_DEFAULT_WIDTH) begin : g_pkg_parity
    assign in_parity = registro_parity(registro_word_t'(bus.in));
  end else begin : g_wide_parity
    assign in_parity = ^bus.in;
  end

  registro_bit u_parity (
    .clock   (clock),
    .rst_n   (rst_n),
    .rst_val (ResetParity),
    .we      (bus.we),
    .d       (in_parity),
    .q       (parity_q)
  );

  assign bus.parity = parity_q;
`endif

endmodule

// File: tb/tb_registro.sv
// Self-checking bench for registro: directed scenarios plus randomized traffic against a
// behavioural model of the stored word. Parity checks are enabled with REGISTRO_PARITY_EN.
module tb_registro;

  localparam int unsigned WIDTH = 8;
  localparam logic [WIDTH-1:0] RV = 8'h00;

  logic clock;
  logic rst_n;

  registro_if #(.WIDTH(WIDTH)) bus ();

  registro #(
    .WIDTH       (WIDTH),
    .RESET_VALUE (RV)
  ) dut (
    .clock (clock),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Rising edge every 4 time units.
  initial clock = 1'b0;
  always #2 clock = ~clock;

  int n_cmp;
  int n_err;
  logic [WIDTH-1:0] model;

  // Drive one edge's worth of inputs, advance the model, then sample 1 unit after the edge.
  task automatic step(input logic r, input logic w, input logic [WIDTH-1:0] d);
    rst_n  = r;
    bus.we = w;
    bus.in = d;
    if (!r)     model = RV;
    else if (w) model = d;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    step(1'b0, 1'b1, 8'hFF);
    n_cmp++;
    if (bus.out !== 8'h00) begin
      n_err++;
      $display("FAIL t1_reset out=%h want=%h", bus.out, 8'h00);
    end
  endtask

  task automatic test_hold();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 8'd7);
      n_cmp++;
      if (bus.out !== 8'h00) begin
        n_err++;
        $display("FAIL t2_hold[%0d] out=%h want=%h", i, bus.out, 8'h00);
      end
    end
  endtask

  task automatic test_write_seq();
    logic [WIDTH-1:0] seq [3];
    seq[0] = 8'd7;
    seq[1] = 8'd12;
    seq[2] = 8'd5;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, seq[i]);
      n_cmp++;
      if (bus.out !== seq[i]) begin
        n_err++;
        $display("FAIL t3_write[%0d] out=%h want=%h", i, bus.out, seq[i]);
      end
    end
  endtask

  task automatic test_glitch();
    step(1'b1, 1'b0, 8'd5);
    // Pulse between edges, restored before the next rising edge.
    bus.in = 8'hAA;
    bus.we = 1'b1;
    #1;
    bus.in = 8'd5;
    bus.we = 1'b0;
    @(posedge clock);
    #1;
    n_cmp++;
    if (bus.out !== 8'd5) begin
      n_err++;
      $display("FAIL t4_glitch out=%h want=%h", bus.out, 8'd5);
    end
  endtask

  task automatic test_sync_reset();
    step(1'b1, 1'b1, 8'd5);
    rst_n  = 1'b0;
    bus.we = 1'b0;
    #1;
    n_cmp++;
    if (bus.out !== 8'd5) begin
      n_err++;
      $display("FAIL t5_no_async_clear out=%h want=%h", bus.out, 8'd5);
    end
    model = RV;
    @(posedge clock);
    #1;
    n_cmp++;
    if (bus.out !== 8'h00) begin
      n_err++;
      $display("FAIL t5_sync_reset out=%h want=%h", bus.out, 8'h00);
    end
  endtask

`ifdef REGISTRO_PARITY_EN
  task automatic test_parity();
    step(1'b1, 1'b1, 8'h07);
    n_cmp++;
    if (bus.parity !== 1'b1) begin
      n_err++;
      $display("FAIL t6_parity_07 parity=%b want=1", bus.parity);
    end
    step(1'b1, 1'b1, 8'h0C);
    n_cmp++;
    if (bus.parity !== 1'b0) begin
      n_err++;
      $display("FAIL t6_parity_0c parity=%b want=0", bus.parity);
    end
    step(1'b1, 1'b1, 8'h01);
    step(1'b0, 1'b0, 8'h00);
    n_cmp++;
    if (bus.parity !== 1'b0) begin
      n_err++;
      $display("FAIL t6_parity_reset parity=%b want=0", bus.parity);
    end
  endtask
`endif

  task automatic test_back_to_back();
    logic [WIDTH-1:0] d;
    for (int i = 0; i < 8; i++) begin
      d = WIDTH'($urandom);
      step(1'b1, 1'b1, d);
      n_cmp++;
      if (bus.out !== d) begin
        n_err++;
        $display("FAIL b2b[%0d] out=%h want=%h", i, bus.out, d);
      end
    end
  endtask

  task automatic test_random();
    logic             r;
    logic             w;
    logic [WIDTH-1:0] d;
    for (int i = 0; i < 300; i++) begin
      r = ($urandom_range(0, 9) != 0);
      w = 1'($urandom);
      d = WIDTH'($urandom);
      step(r, w, d);
      n_cmp++;
      if (bus.out !== model) begin
        n_err++;
        $display("FAIL random[%0d] out=%h want=%h (rst_n=%b we=%b in=%h)",
                 i, bus.out, model, r, w, d);
      end
`ifdef REGISTRO_PARITY_EN
      n_cmp++;
      if (bus.parity !== ^model) begin
        n_err++;
        $display("FAIL random_parity[%0d] parity=%b want=%b", i, bus.parity, ^model);
      end
`endif
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_err  = 0;
    model  = 'x;
    rst_n  = 1'b0;
    bus.we = 1'b0;
    bus.in = '0;
    #1;
    test_reset();
    test_hold();
    test_write_seq();
    test_glitch();
    test_sync_reset();
`ifdef REGISTRO_PARITY_EN
    test_parity();
`endif
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
